// File: rtl/ball_locate_if.sv
// Pixel-stream and result bundle between the image pipeline and ball_locate.
// The master drives processed pixels; the slave (ball_locate) returns the per-frame results.
interface ball_locate_if #(
  parameter int C_NB_BUF      = 12,
  parameter int C_NB_IMG_PXLS = 13
);
  logic                     proc_we;
  logic [C_NB_BUF-1:0]      proc_pxl;
  logic [C_NB_IMG_PXLS-1:0] proc_addr;
  logic                     pos_valid;
  logic                     ball_found;
  logic [1:0]               ball_dir;
  logic                     sync_err;
  logic [7:0]               leds;

  modport master (
    output proc_we, proc_pxl, proc_addr,
    input  pos_valid, ball_found, ball_dir, sync_err, leds
  );

  modport slave (
    input  proc_we, proc_pxl, proc_addr,
    output pos_valid, ball_found, ball_dir, sync_err, leds
  );
endinterface

// File: rtl/ball_locate.sv
// Counts strongly red pixels per image region over a full frame and reports
// whether a ball is present and in which third of the image it sits.
module ball_locate #(
  parameter int C_IMG_COLS    = 80,
  parameter int C_IMG_ROWS    = 60,
  parameter int C_NB_IMG_PXLS = 13,
  parameter int C_NB_BUF      = 12,
  parameter int C_LEFT_END    = 26,
  parameter int C_RIGHT_BEG   = 54,
  parameter int C_MIN_PXLS    = 16
) (
  input  logic          clk,
  input  logic          rst,
  ball_locate_if.slave  bus
);

  localparam int COL_W = (C_IMG_COLS > 1) ? $clog2(C_IMG_COLS) : 1;
  localparam int ROW_W = (C_IMG_ROWS > 1) ? $clog2(C_IMG_ROWS) : 1;
  localparam int NB    = C_NB_IMG_PXLS;
  localparam int TOT_W = C_NB_IMG_PXLS + 2;

  // MSB of each RGB channel: red is the top third of the pixel word.
  localparam int R_BIT = C_NB_BUF - 1;
  localparam int G_BIT = (2 * C_NB_BUF) / 3 - 1;
  localparam int B_BIT = C_NB_BUF / 3 - 1;

  localparam logic [COL_W-1:0] LEFT_END  = COL_W'(C_LEFT_END);
  localparam logic [COL_W-1:0] RIGHT_BEG = COL_W'(C_RIGHT_BEG);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(C_IMG_COLS - 1);
  localparam logic [NB-1:0]    ADDR_LAST = NB'(C_IMG_COLS * C_IMG_ROWS - 1);
  localparam logic [TOT_W-1:0] MIN_PXLS  = TOT_W'(C_MIN_PXLS);

  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;
  typedef enum logic [1:0] {
    DIR_NONE   = 2'b00,
    DIR_LEFT   = 2'b01,
    DIR_CENTRE = 2'b10,
    DIR_RIGHT  = 2'b11
  } dir_t;

  state_t           state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [NB-1:0]    exp_addr;
  logic [NB-1:0]    cnt_l, cnt_c, cnt_r;
  logic             pos_valid_q, sync_err_q, found_q;
  dir_t             dir_q;
  logic [3:0]       frame_cnt;

  logic             hot, in_seq, mismatch, frame_start, last_pxl;
  logic [COL_W-1:0] cur_col, col_nxt;
  logic [ROW_W-1:0] cur_row, row_nxt;
  logic [NB-1:0]    exp_nxt, l_nxt, c_nxt, r_nxt;
  logic [TOT_W-1:0] total;
  logic             found_nxt;
  dir_t             dir_nxt;

  // A pixel either continues the current frame (in_seq) or, with address 0,
  // opens a new one from zeroed counts; both paths share the same update logic.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    hot         = bus.proc_pxl[R_BIT] & ~bus.proc_pxl[G_BIT] & ~bus.proc_pxl[B_BIT];
    in_seq      = bus.proc_we && (state == ACCUM) && (bus.proc_addr == exp_addr);
    mismatch    = bus.proc_we && (state == ACCUM) && (bus.proc_addr != exp_addr);
    frame_start = bus.proc_we && (bus.proc_addr == '0) && !in_seq;
    last_pxl    = in_seq && (bus.proc_addr == ADDR_LAST);

    cur_col = in_seq ? col      : '0;
    cur_row = in_seq ? row      : '0;
    exp_nxt = (in_seq ? exp_addr : '0) + NB'(1);
    l_nxt   = in_seq ? cnt_l    : '0;
    c_nxt   = in_seq ? cnt_c    : '0;
    r_nxt   = in_seq ? cnt_r    : '0;

    if (hot) begin
      if (cur_col < LEFT_END) begin
        if (l_nxt != '1) l_nxt = l_nxt + NB'(1);
      end else if (cur_col < RIGHT_BEG) begin
        if (c_nxt != '1) c_nxt = c_nxt + NB'(1);
      end else begin
        if (r_nxt != '1) r_nxt = r_nxt + NB'(1);
      end
    end

    if (cur_col == COL_LAST) begin
      col_nxt = '0;
      row_nxt = cur_row + ROW_W'(1);
    end else begin
      col_nxt = cur_col + COL_W'(1);
      row_nxt = cur_row;
    end

    total     = TOT_W'(l_nxt) + TOT_W'(c_nxt) + TOT_W'(r_nxt);
    found_nxt = 1'b0;
    dir_nxt   = DIR_NONE;
    if (total >= MIN_PXLS) begin
      found_nxt = 1'b1;
      if (c_nxt >= l_nxt && c_nxt >= r_nxt) dir_nxt = DIR_CENTRE;
      else if (l_nxt >= r_nxt)              dir_nxt = DIR_LEFT;
      else                                  dir_nxt = DIR_RIGHT;
    end
  end

  // Results are latched on the edge that accepts the last pixel, so they are
  // already stable during the single REPORT cycle that carries pos_valid.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      exp_addr    <= '0;
      cnt_l       <= '0;
      cnt_c       <= '0;
      cnt_r       <= '0;
      pos_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      found_q     <= 1'b0;
      dir_q       <= DIR_NONE;
      frame_cnt   <= '0;
    end else begin
      pos_valid_q <= 1'b0;
      sync_err_q  <= mismatch;

      if (last_pxl) begin
        state       <= REPORT;
        pos_valid_q <= 1'b1;
        found_q     <= found_nxt;
        dir_q       <= dir_nxt;
        frame_cnt   <= frame_cnt + 4'd1;
        cnt_l       <= l_nxt;
        cnt_c       <= c_nxt;
        cnt_r       <= r_nxt;
      end else if (frame_start || in_seq) begin
        state    <= ACCUM;
        col      <= col_nxt;
        row      <= row_nxt;
        exp_addr <= exp_nxt;
        cnt_l    <= l_nxt;
        cnt_c    <= c_nxt;
        cnt_r    <= r_nxt;
      end else if (mismatch || state == REPORT) begin
        state    <= IDLE;
        col      <= '0;
        row      <= '0;
        exp_addr <= '0;
        cnt_l    <= '0;
        cnt_c    <= '0;
        cnt_r    <= '0;
      end
    end
  end

  assign bus.pos_valid  = pos_valid_q;
  assign bus.sync_err   = sync_err_q;
  assign bus.ball_found = found_q;
  assign bus.ball_dir   = dir_q;
  assign bus.leds       = {found_q, dir_q, 1'b0, frame_cnt};

endmodule

// File: tb/tb_ball_locate.sv
// Self-checking bench for ball_locate: randomized frames feed a frame-level
// reference model whose expected reports are checked by a decoupled monitor.
module tb_ball_locate;

  localparam int COLS      = 80;
  localparam int ROWS      = 60;
  localparam int NPIX      = COLS * ROWS;
  localparam int NB_BUF    = 12;
  localparam int NB_ADDR   = 13;
  localparam int LEFT_END  = 26;
  localparam int RIGHT_BEG = 54;
  localparam int MIN_PXLS  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ball_locate_if #(.C_NB_BUF(NB_BUF), .C_NB_IMG_PXLS(NB_ADDR)) bus ();

  ball_locate #(
    .C_IMG_COLS(COLS), .C_IMG_ROWS(ROWS), .C_NB_IMG_PXLS(NB_ADDR),
    .C_NB_BUF(NB_BUF), .C_LEFT_END(LEFT_END), .C_RIGHT_BEG(RIGHT_BEG),
    .C_MIN_PXLS(MIN_PXLS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         found;
    bit [1:0]   dir;
    logic [7:0] leds;
  } report_t;

  report_t     rep_q[$];
  int          sync_q[$];
  report_t     mon_r;
  logic [11:0] frame [NPIX];

  // Frame-level reference model state
  bit       m_active = 0;
  int       m_exp = 0, m_l = 0, m_c = 0, m_r = 0, m_fcnt = 0;
  bit       m_found = 0;
  bit [1:0] m_dir = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_hot(input logic [11:0] p);
    return p[11] && !p[7] && !p[3];
  endfunction

  function automatic logic [7:0] model_leds();
    return {m_found, m_dir, 1'b0, 4'(m_fcnt)};
  endfunction

  task automatic model_pixel(input int addr, input logic [11:0] p, input int acc);
    int col, total;
    report_t r;
    if (m_active && addr != m_exp) begin
      sync_q.push_back(acc);
      m_active = 0;
    end
    if (!m_active) begin
      if (addr != 0) return;
      m_active = 1; m_exp = 0; m_l = 0; m_c = 0; m_r = 0;
    end
    col = addr % COLS;
    if (is_hot(p)) begin
      if (col < LEFT_END)       m_l++;
      else if (col < RIGHT_BEG) m_c++;
      else                      m_r++;
    end
    m_exp++;
    if (addr == NPIX - 1) begin
      total = m_l + m_c + m_r;
      if (total < MIN_PXLS) begin
        m_found = 0; m_dir = 2'b00;
      end else begin
        m_found = 1;
        if (m_c >= m_l && m_c >= m_r) m_dir = 2'b10;
        else if (m_l >= m_r)          m_dir = 2'b01;
        else                          m_dir = 2'b11;
      end
      m_fcnt   = (m_fcnt + 1) % 16;
      r.cyc    = acc;
      r.found  = m_found;
      r.dir    = m_dir;
      r.leds   = model_leds();
      rep_q.push_back(r);
      m_active = 0;
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_exp = 0; m_l = 0; m_c = 0; m_r = 0;
    m_fcnt = 0; m_found = 0; m_dir = 2'b00;
  endtask

  // Called just after a rising edge; the next edge accepts what is driven here.
  task automatic drive(input bit we, input int addr, input logic [11:0] p);
    int acc;
    bus.proc_we   = we;
    bus.proc_addr = NB_ADDR'(addr);
    bus.proc_pxl  = p;
    acc = cyc + 1;
    if (we) model_pixel(addr, p, acc);
    @(posedge clk);
    #1;
  endtask

  // Gaps never precede pixel 0, so consecutive frames hit the REPORT cycle.
  task automatic send(input int addr, input logic [11:0] p, input int gap_pct);
    if (addr != 0)
      while ($urandom_range(99) < gap_pct)
        drive(1'b0, $urandom_range(NPIX - 1), 12'($urandom));
    drive(1'b1, addr, p);
  endtask

  task automatic send_range(input int first, input int last, input int gap_pct);
    for (int a = first; a <= last; a++) send(a, frame[a], gap_pct);
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 12'h000);
  endtask

  task automatic fill_background();
    logic [11:0] p;
    for (int i = 0; i < NPIX; i++) begin
      p = 12'($urandom);
      if (is_hot(p)) p[3] = 1'b1;
      frame[i] = p;
    end
  endtask

  task automatic set_hot(input int col, input int row);
    logic [11:0] p;
    p = 12'($urandom);
    p[11] = 1'b1; p[7] = 1'b0; p[3] = 1'b0;
    frame[row * COLS + col] = p;
  endtask

  task automatic random_hot(input int max_n);
    int n;
    n = $urandom_range(max_n);
    for (int i = 0; i < n; i++) set_hot($urandom_range(COLS - 1), $urandom_range(ROWS - 1));
  endtask

  task automatic check_results(input string name);
    check({name, "_leds"}, bus.leds, model_leds());
    check({name, "_found"}, bus.ball_found, m_found);
    check({name, "_dir"}, bus.ball_dir, m_dir);
  endtask

  // Asserts rst mid-cycle so its asynchronous effect is visible before any edge.
  task automatic do_reset();
    bus.proc_we = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_pos_valid", bus.pos_valid, 1'b0);
    check("rst_sync_err", bus.sync_err, 1'b0);
    check("rst_leds", bus.leds, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // Monitor: every pos_valid / sync_err pulse must match the next expectation
  // in cycle and content; an expectation whose cycle passes unmatched is missed.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.pos_valid) begin
        if (rep_q.size() == 0) check("pos_valid_unexpected", bus.pos_valid, 1'b0);
        else begin
          mon_r = rep_q.pop_front();
          check("pos_valid_cycle", cyc, mon_r.cyc);
          check("report_found", bus.ball_found, mon_r.found);
          check("report_dir", bus.ball_dir, mon_r.dir);
          check("report_leds", bus.leds, mon_r.leds);
        end
      end else if (rep_q.size() > 0 && rep_q[0].cyc <= cyc) begin
        check("pos_valid_missing", bus.pos_valid, 1'b1);
        rep_q.delete(0);
      end
      if (bus.sync_err) begin
        if (sync_q.size() == 0) check("sync_err_unexpected", bus.sync_err, 1'b0);
        else check("sync_err_cycle", cyc, sync_q.pop_front());
      end else if (sync_q.size() > 0 && sync_q[0] <= cyc) begin
        check("sync_err_missing", bus.sync_err, 1'b1);
        sync_q.delete(0);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    bus.proc_we   = 1'b0;
    bus.proc_addr = '0;
    bus.proc_pxl  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("init_pos_valid", bus.pos_valid, 1'b0);
    check("init_sync_err", bus.sync_err, 1'b0);
    check("init_leds", bus.leds, 8'h00);
    rst = 1'b0;
    model_reset();

    // All-black frame: no ball, frame counter reads one.
    for (int i = 0; i < NPIX; i++) frame[i] = 12'h000;
    send_range(0, NPIX - 1, 0);
    settle(2);
    check("zero_frame_leds", bus.leds, 8'h01);
    check_results("zero_frame");

    // 5x5 red block in the right region.
    fill_background();
    for (int r = 10; r < 15; r++)
      for (int c = 60; c < 65; c++) set_hot(c, r);
    send_range(0, NPIX - 1, 0);
    settle(2);
    check("block_dir", bus.ball_dir, 2'b11);
    check_results("block");

    // Left/centre tie resolves to centre.
    fill_background();
    for (int r = 0; r < 20; r++) begin
      set_hot(10, r);
      set_hot(30, r);
    end
    send_range(0, NPIX - 1, 0);
    settle(2);
    check("tie_dir", bus.ball_dir, 2'b10);
    check_results("tie");

    // One pixel short of the detection threshold.
    fill_background();
    for (int r = 20; r < 35; r++) set_hot(40, r);
    send_range(0, NPIX - 1, 0);
    settle(2);
    check("below_min_found", bus.ball_found, 1'b0);
    check_results("below_min");

    // Random content with random idle gaps.
    for (int f = 0; f < 2; f++) begin
      fill_background();
      random_hot(60);
      send_range(0, NPIX - 1, 20);
      settle(2);
      check_results("random");
    end

    // Address skip 100 -> 102: frame abandoned, results unchanged.
    fill_background();
    random_hot(60);
    send_range(0, 100, 0);
    send_range(102, NPIX - 1, 0);
    settle(2);
    check_results("addr_skip");

    // Unexpected pixel 0 restarts the frame immediately.
    fill_background();
    random_hot(60);
    send_range(0, 50, 0);
    send_range(0, NPIX - 1, 10);
    settle(2);
    check_results("restart");

    // Back-to-back frames from reset, pixel 0 landing in the REPORT cycle.
    do_reset();
    fill_background();
    random_hot(60);
    send_range(0, NPIX - 1, 15);
    fill_background();
    random_hot(60);
    send_range(0, NPIX - 1, 15);
    settle(2);
    check("b2b_frame_cnt", bus.leds[3:0], 4'd2);
    check_results("b2b");

    // Reset in the middle of a frame, then a clean frame.
    fill_background();
    random_hot(60);
    send_range(0, 2000, 0);
    do_reset();
    fill_background();
    for (int r = 30; r < 35; r++)
      for (int c = 2; c < 7; c++) set_hot(c, r);
    send_range(0, NPIX - 1, 0);
    settle(2);
    check("post_rst_frame_cnt", bus.leds[3:0], 4'd1);
    check_results("post_rst");

    settle(2);
    check("report_queue_drained", rep_q.size(), 0);
    check("sync_queue_drained", sync_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ball_locate.md
BALL_LOCATE -- requirements
Module: ball_locate

Interface
REQ-001 Parameter C_IMG_COLS, default 80: pixels per image row.
REQ-002 Parameter C_IMG_ROWS, default 60: rows per image.
REQ-003 Parameter C_NB_IMG_PXLS, default 13: pixel address width.
REQ-004 Parameter C_NB_BUF, default 12: pixel width, RGB444, red in [11:8], green in [7:4], blue in [3:0].
REQ-005 Parameter C_LEFT_END, default 26: first column of the centre region.
REQ-006 Parameter C_RIGHT_BEG, default 54: first column of the right region.
REQ-007 Parameter C_MIN_PXLS, default 16: minimum hot-pixel total for a detection.
REQ-008 Reset: one clock; reset is asynchronous and active-high.
REQ-009 clk  in  1  fpga clock.
REQ-010 rst  in  1  asynchronous reset, active high.
REQ-011 proc_we  in  1  processed-pixel strobe; the pixel is accepted on the rising clk edge when this is high.
REQ-012 proc_pxl  in  C_NB_BUF  processed pixel.
REQ-013 proc_addr  in  C_NB_IMG_PXLS  processed pixel address, row-major order.
REQ-014 pos_valid  out  1  one-cycle pulse when new results are available.
REQ-015 ball_found  out  1  hot-pixel total of the last frame is at least C_MIN_PXLS.
REQ-016 ball_dir  out  2  last-frame direction: 00 none, 01 left, 10 centre, 11 right.
REQ-017 sync_err  out  1  one-cycle pulse on an address discontinuity.
REQ-018 leds  out  8  {ball_found, ball_dir, 1'b0, frame_cnt[3:0]}.

Function
REQ-019 The block SHALL classify a pixel as hot when proc_pxl[11]=1, proc_pxl[7]=0 and proc_pxl[3]=0.
REQ-020 The block SHALL implement a state machine with states IDLE, ACCUM and REPORT.
REQ-021 IDLE: the block SHALL ignore pixels until an accepted pixel has proc_addr=0, then enter ACCUM with that pixel counted.
REQ-022 The block SHALL track position with internal column and row counters, not with division or modulo of proc_addr.
REQ-023 The column counter SHALL wrap from C_IMG_COLS-1 to 0 and increment the row counter.
REQ-024 The block SHALL check each accepted pixel in ACCUM against an internal expected address, which increments by 1 per accepted pixel.
REQ-025 On an address mismatch with proc_addr=0, the block SHALL pulse sync_err, clear all counts, and restart the frame counting that pixel.
REQ-026 On an address mismatch with proc_addr≠0, the block SHALL pulse sync_err, clear all counts, and enter IDLE.
REQ-027 Region membership: left when col<C_LEFT_END; centre when C_LEFT_END≤col<C_RIGHT_BEG; right otherwise.
REQ-028 The three region counters SHALL be C_NB_IMG_PXLS bits wide and saturate at all-ones.
REQ-029 When the accepted pixel has address C_IMG_COLS*C_IMG_ROWS-1, the block SHALL count that pixel and enter REPORT on the next edge.
REQ-030 REPORT lasts exactly one cycle; during it the block SHALL register ball_found and ball_dir and assert pos_valid.
REQ-031 Latency: pos_valid SHALL be high in the cycle directly after the edge that accepted the last pixel.
REQ-032 The block SHALL compute total = left+centre+right in C_NB_IMG_PXLS+2 bits.
REQ-033 If total<C_MIN_PXLS, the block SHALL set ball_found=0 and ball_dir=00.
REQ-034 Otherwise ball_dir SHALL be the region with the largest count; on a tie, centre wins over left and left wins over right.
REQ-035 REPORT SHALL clear the region counters and go to IDLE; a proc_we with proc_addr=0 in the REPORT cycle SHALL be accepted as pixel 0 of the new frame (go to ACCUM).
REQ-036 frame_cnt (4 bits) SHALL increment at every REPORT and wrap 15→0.
REQ-037 ball_found and ball_dir SHALL hold their values until the next REPORT; aborted frames leave them unchanged.
REQ-038 proc_we=0 cycles SHALL be tolerated at any point with no state change.

Reset
REQ-039 rst=1 SHALL immediately force: state IDLE, all counters 0, pos_valid=0, sync_err=0, ball_found=0, ball_dir=00, frame_cnt=0, leds=8'h00.
REQ-040 Reset asserted mid-frame SHALL discard the partial frame, and no pos_valid SHALL follow.

Verification
REQ-041 Scenario: a 4800-pixel frame, all pixels 12'h000 → pos_valid pulses once, ball_found=0, ball_dir=00, leds=8'h01.
REQ-042 Scenario: a frame with a 5x5 block of 12'hF00 at columns 60-64 → ball_found=1, ball_dir=11, pos_valid one cycle after pixel 4799.
REQ-043 Scenario: 20 hot pixels at column 10 and 20 at column 30 (a tie) → ball_dir=10; 15 hot pixels total → ball_found=0.
REQ-044 Scenario: proc_addr jumps from 100 to 102 → sync_err pulses, state IDLE, and no pos_valid for that frame.
REQ-045 Scenario: back-to-back frames with pixel 0 in the REPORT cycle, plus random proc_we gaps → two pos_valid pulses and frame_cnt=2.
REQ-046 Scenario: rst asserted at pixel 2000 → outputs reset at once, and the next full frame reports correctly.
